accel_run_ctrl: RTL and testbench

Parametrised run-control and status block for the DNN accelerator core. It sequences a convolution pass across `NUM_ENGINE` compute or accumulate engines, aggregates their done flags, times execution with a saturating cycle counter, and asserts a stretched soft reset to the engines. It also exposes a PS-readable register window holding timer, status and optional debug counters. It sits between the PS config registers and the line-KCPE engine / psum accumulator instances inside the core wrapper.

---
 rtl/accel_run_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_accel_run_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_run_ctrl.sv
// Run-control and status block for the DNN accelerator core: sequences a pass across
// NUM_ENGINE engines, times it, stretches the engine reset and serves a PS read window.
// Build option: ACCEL_RUN_CTRL_DBG_EN maps the debug counter words into the read window.
//
// state | meaning
// IDLE  | waiting for enable with soft reset low
// RUN   | engines enabled, collecting sticky done flags
// DRAIN | all engines done, waiting DRAIN_CYCLES clocks for pipelines to empty
// DONE  | run finished, timer frozen, waiting for enable to drop
module accel_run_ctrl #(
    parameter int unsigned NUM_ENGINE   = 2,
    parameter int unsigned REG_WIDTH    = 32,
    parameter int unsigned NUM_DBG      = 13,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic [REG_WIDTH-1:0] BASE_ADDR = REG_WIDTH'(32'hF0000000)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [REG_WIDTH-1:0]         i_conf_ctrl,
    input  logic [NUM_ENGINE-1:0]        i_engine_done,
    input  logic [NUM_DBG*REG_WIDTH-1:0] i_dbg,
    output logic                         o_engine_enb,
    output logic                         o_rst_engine,
    output logic                         o_irq,
    output logic [REG_WIDTH-1:0]         o_conf_status,
    input  logic [REG_WIDTH-1:0]         ps_addr,
    input  logic                         ps_rden,
    output logic [REG_WIDTH-1:0]         ps_rdat,
    output logic                         ps_rvld
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int unsigned WW = REG_WIDTH - 2;
    localparam logic [3:0] DRAIN_LOAD = (DRAIN_CYCLES == 0) ? 4'd0 : 4'(DRAIN_CYCLES - 1);

    logic                  enable;
    logic                  soft_rst;
    logic [1:0]            state_q, state_d;
    logic [REG_WIDTH-1:0]  timer_q, timer_d, timer_inc;
    logic [NUM_ENGINE-1:0] sticky_q, sticky_d;
    logic                  sat_q, sat_d;
    logic [3:0]            drain_q, drain_d;
    logic                  irq_q, irq_d;
    logic                  enb_q;
    logic                  soft_q;
    logic                  rst_eng_q;
    logic [31:0]           status_w32;
    logic [REG_WIDTH-1:0]  status_w;
    logic [REG_WIDTH-1:0]  rd_off;
    logic [WW-1:0]         rd_word;
    logic                  rd_hit;
    logic [REG_WIDTH-1:0]  rd_data;
    logic                  rvld_q;
    logic [REG_WIDTH-1:0]  rdat_q;
    logic                  unused_rd;

    assign enable    = i_conf_ctrl[0];
    assign soft_rst  = i_conf_ctrl[1];
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        sticky_d = sticky_q;
        sat_d    = sat_q;
        drain_d  = drain_q;
        irq_d    = 1'b0;
        if (soft_rst) begin
            state_d  = S_IDLE;
            timer_d  = '0;
            sticky_d = '0;
            sat_d    = 1'b0;
            drain_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_d  = S_RUN;
                        timer_d  = '0;
                        sticky_d = '0;
                    end
                end
                S_RUN: begin
                    timer_d  = timer_inc;
                    sat_d    = sat_q | (timer_inc == '1);
                    sticky_d = sticky_q | i_engine_done;
                    if (&sticky_d) begin
                        if (DRAIN_CYCLES == 0) begin
                            state_d = S_DONE;
                            irq_d   = 1'b1;
                        end else begin
                            state_d = S_DRAIN;
                            drain_d = DRAIN_LOAD;
                        end
                    end
                end
                S_DRAIN: begin
                    timer_d = timer_inc;
                    sat_d   = sat_q | (timer_inc == '1);
                    if (drain_q == 4'd0) begin
                        state_d = S_DONE;
                        irq_d   = 1'b1;
                    end else begin
                        drain_d = drain_q - 4'd1;
                    end
                end
                S_DONE: begin
                    if (!enable) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Status word is assembled at 32 bits and then fitted to the bus width.
    assign status_w32 = {6'b0, rst_eng_q, sat_q, 6'b0, state_q, 16'(sticky_q)};

    generate
        if (REG_WIDTH >= 32) begin : g_status_wide
            assign status_w = REG_WIDTH'(status_w32);
        end else begin : g_status_narrow
            assign status_w = status_w32[REG_WIDTH-1:0];
        end
    endgenerate

    // Offset wraps for addresses below the base, so they fall out of the window.
    assign rd_off  = ps_addr - BASE_ADDR;
    assign rd_word = rd_off[REG_WIDTH-1:2];

    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        if (rd_word == WW'(0)) begin
            rd_hit  = 1'b1;
            rd_data = timer_q;
        end else if (rd_word == WW'(1)) begin
            rd_hit  = 1'b1;
            rd_data = status_w;
        end
`ifdef ACCEL_RUN_CTRL_DBG_EN
        else begin
            for (int i = 0; i < int'(NUM_DBG); i++) begin
                if (rd_word == WW'(i + 2)) begin
                    rd_hit  = 1'b1;
                    rd_data = i_dbg[i*REG_WIDTH +: REG_WIDTH];
                end
            end
        end
`endif
    end

`ifdef ACCEL_RUN_CTRL_DBG_EN
    assign unused_rd = ^rd_off[1:0];
`else
    assign unused_rd = ^{rd_off[1:0], i_dbg};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            sticky_q  <= '0;
            sat_q     <= 1'b0;
            drain_q   <= '0;
            irq_q     <= 1'b0;
            enb_q     <= 1'b0;
            soft_q    <= 1'b0;
            rst_eng_q <= 1'b1;
            rvld_q    <= 1'b0;
            rdat_q    <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            sticky_q  <= sticky_d;
            sat_q     <= sat_d;
            drain_q   <= drain_d;
            irq_q     <= irq_d;
            enb_q     <= (state_d == S_RUN);
            soft_q    <= soft_rst;
            // Registered copy of soft reset stretches the engine reset by one clock.
            rst_eng_q <= soft_rst | soft_q;
            rvld_q    <= ps_rden & rd_hit;
            rdat_q    <= (ps_rden & rd_hit) ? rd_data : '0;
        end
    end

    assign o_engine_enb  = enb_q;
    assign o_rst_engine  = rst_eng_q;
    assign o_irq         = irq_q;
    assign o_conf_status = status_w;
    assign ps_rdat       = rdat_q;
    assign ps_rvld       = rvld_q;

endmodule

// File: tb/tb_accel_run_ctrl.sv
// Self-checking bench for accel_run_ctrl: directed steps plus randomized runs checked
// against a cycle-count model of the run sequence; a narrow instance covers saturation.
module tb_accel_run_ctrl;

    localparam int D    = 3;
    localparam int NDBG = 13;
    localparam logic [31:0] BASE = 32'hF0000000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       conf;
    logic [1:0]        done;
    logic [NDBG*32-1:0] dbg;
    logic              enb, rst_eng, irq;
    logic [31:0]       status;
    logic [31:0]       ps_addr;
    logic              ps_rden;
    logic [31:0]       ps_rdat;
    logic              ps_rvld;

    logic [7:0]        conf8;
    logic [0:0]        done8;
    logic [NDBG*8-1:0] dbg8;
    logic              enb8, rst8, irq8;
    logic [7:0]        status8;
    logic [7:0]        addr8;
    logic              rden8;
    logic [7:0]        rdat8;
    logic              rvld8;

    logic [31:0] dbg_words [NDBG];
    int total = 0;
    int bad   = 0;

    accel_run_ctrl dut (
        .clk(clk), .rst_n(rst_n), .i_conf_ctrl(conf), .i_engine_done(done), .i_dbg(dbg),
        .o_engine_enb(enb), .o_rst_engine(rst_eng), .o_irq(irq), .o_conf_status(status),
        .ps_addr(ps_addr), .ps_rden(ps_rden), .ps_rdat(ps_rdat), .ps_rvld(ps_rvld)
    );

    accel_run_ctrl #(
        .NUM_ENGINE(1), .REG_WIDTH(8), .NUM_DBG(NDBG), .DRAIN_CYCLES(0), .BASE_ADDR(8'h40)
    ) dut8 (
        .clk(clk), .rst_n(rst_n), .i_conf_ctrl(conf8), .i_engine_done(done8), .i_dbg(dbg8),
        .o_engine_enb(enb8), .o_rst_engine(rst8), .o_irq(irq8), .o_conf_status(status8),
        .ps_addr(addr8), .ps_rden(rden8), .ps_rdat(rdat8), .ps_rvld(rvld8)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ps_rd(input logic [31:0] a, output logic [31:0] d, output logic v);
        ps_addr = a;
        ps_rden = 1'b1;
        tick();
        d = ps_rdat;
        v = ps_rvld;
        ps_rden = 1'b0;
        ps_addr = '0;
    endtask

    // Model: run finishes when the last engine's done arrives at RUN cycle n; DRAIN
    // follows for D cycles, irq marks the first DONE cycle, timer ends at n+1+D.
    task automatic do_run(input int t0, input int t1, input bit l0, input bit l1,
                          input bit drop_en);
        int n;
        int irq_n;
        logic [1:0] exp_st;
        logic [31:0] d;
        logic v;
        n = (t0 > t1) ? t0 : t1;
        conf = 0;
        done = 0;
        tick();
        chk("pre_run_idle", 32'(status[17:16]), 0);
        conf = 1;
        tick();
        irq_n = 0;
        for (int c = 0; c <= n + D + 3; c++) begin
            if (c <= n) exp_st = 2'd1;
            else if (c <= n + D) exp_st = 2'd2;
            else if (drop_en && c > n + D + 1) exp_st = 2'd0;
            else exp_st = 2'd3;
            chk("run_state", 32'(status[17:16]), 32'(exp_st));
            chk("run_enb", 32'(enb), 32'(exp_st == 2'd1));
            if (irq) begin
                irq_n++;
                chk("irq_cycle", c, n + D + 1);
            end
            if (c == 1) begin
                chk("first_cycle_timer_vld", 32'(ps_rvld), 1);
                chk("first_cycle_timer", ps_rdat, 0);
                ps_rden = 1'b0;
            end
            if (c == 0) begin
                ps_addr = BASE;
                ps_rden = 1'b1;
            end
            done[0] = l0 ? (c >= t0) : (c == t0);
            done[1] = l1 ? (c >= t1) : (c == t1);
            if (drop_en && c == 1) conf = 0;
            tick();
        end
        chk("irq_count", irq_n, 1);
        done = 0;
        ps_rd(BASE, d, v);
        chk("end_timer", d, 32'(n + 1 + D));
        ps_rd(BASE + 4, d, v);
        chk("end_status", d, drop_en ? 32'h0000_0003 : 32'h0003_0003);
    endtask

    initial begin
        logic [31:0] d;
        logic v;
        rst_n = 1'b0;
        conf = 0; done = 0; ps_addr = 0; ps_rden = 0;
        conf8 = 0; done8 = 0; addr8 = 0; rden8 = 0; dbg8 = '0;
        for (int i = 0; i < NDBG; i++) begin
            dbg_words[i] = $urandom;
            dbg[i*32 +: 32] = dbg_words[i];
        end

        repeat (3) tick();
        chk("rst_enb", 32'(enb), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_rvld", 32'(ps_rvld), 0);
        chk("rst_rdat", ps_rdat, 0);
        chk("rst_status", status, 32'h0200_0000);
        chk("rst_rst_engine", 32'(rst_eng), 1);
        rst_n = 1'b1;
        tick();
        chk("rel_rst_engine", 32'(rst_eng), 0);
        chk("rel_status", status, 0);

        ps_rd(BASE + 4, d, v);
        chk("rd_status_vld", 32'(v), 1);
        chk("rd_status", d, 0);
        tick();
        chk("rd_vld_one_cycle", 32'(ps_rvld), 0);
        ps_rd(BASE + 5, d, v);
        chk("rd_lowbits_vld", 32'(v), 1);
        ps_rd(BASE + 32'h100, d, v);
        chk("rd_unmapped_vld", 32'(v), 0);
        chk("rd_unmapped_dat", d, 0);
        ps_rd(BASE - 4, d, v);
        chk("rd_below_base_vld", 32'(v), 0);
        ps_rd(BASE + 8 + 4 * NDBG, d, v);
        chk("rd_past_dbg_vld", 32'(v), 0);
        ps_rd(BASE + 8 + 4 * 12, d, v);
`ifdef ACCEL_RUN_CTRL_DBG_EN
        chk("rd_dbg12_vld", 32'(v), 1);
        chk("rd_dbg12", d, dbg_words[12]);
        ps_rd(BASE + 8, d, v);
        chk("rd_dbg0", d, dbg_words[0]);
`else
        chk("rd_dbg12_vld", 32'(v), 0);
        chk("rd_dbg12_dat", d, 0);
`endif

        // Done activity while idle must not reach the sticky flags.
        done = 2'b11;
        tick();
        done = 2'b00;
        tick();
        chk("idle_done_ignored", status, 0);

        do_run(5, 20, 1'b0, 1'b1, 1'b0);

        // Back-to-back reads while frozen in DONE.
        ps_addr = BASE;
        ps_rden = 1'b1;
        tick();
        chk("b2b_timer_vld", 32'(ps_rvld), 1);
        chk("b2b_timer", ps_rdat, 24);
        ps_addr = BASE + 4;
        tick();
        chk("b2b_status_vld", 32'(ps_rvld), 1);
        chk("b2b_status", ps_rdat, 32'h0003_0003);
        ps_rden = 1'b0;
        tick();
        chk("b2b_end_vld", 32'(ps_rvld), 0);

        for (int i = 0; i < 10; i++) begin
            chk("done_hold_state", 32'(status[17:16]), 3);
            chk("done_hold_irq", 32'(irq), 0);
            tick();
        end

        do_run(0, 0, 1'b0, 1'b0, 1'b0);
        do_run(9, 2, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++)
            do_run($urandom_range(0, 25), $urandom_range(0, 25), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Soft reset mid-run at RUN cycle 7.
        conf = 0; done = 0;
        tick();
        conf = 1;
        tick();
        for (int c = 0; c < 7; c++) begin
            done[0] = (c == 3);
            tick();
        end
        done = 0;
        chk("pre_soft_status", status, 32'h0001_0001);
        conf = 3;
        tick();
        chk("soft_state", 32'(status[17:16]), 0);
        chk("soft_status", status, 32'h0200_0000);
        chk("soft_enb", 32'(enb), 0);
        chk("soft_rst_hi1", 32'(rst_eng), 1);
        conf = 0;
        tick();
        chk("soft_rst_hi2", 32'(rst_eng), 1);
        tick();
        chk("soft_rst_lo", 32'(rst_eng), 0);
        ps_rd(BASE, d, v);
        chk("soft_timer", d, 0);

        // Soft reset coinciding with the completing done.
        conf = 1;
        tick();
        done = 2'b01;
        tick();
        tick();
        done = 2'b11;
        conf = 3;
        tick();
        chk("simul_state", 32'(status[17:16]), 0);
        chk("simul_irq", 32'(irq), 0);
        conf = 0; done = 0;
        tick();
        chk("simul_irq2", 32'(irq), 0);
        chk("simul_status", status, 32'h0200_0000);
        tick();
        chk("simul_status2", status, 0);

        // Narrow instance: no drain, direct RUN->DONE, then saturation.
        conf8 = 1;
        tick();
        for (int c = 0; c < 8; c++) begin
            chk("n8_enb", 32'(enb8), 32'(c <= 4));
            chk("n8_irq", 32'(irq8), 32'(c == 5));
            done8 = 1'(c == 4);
            tick();
        end
        addr8 = 8'h40; rden8 = 1; tick(); rden8 = 0;
        chk("n8_timer_vld", 32'(rvld8), 1);
        chk("n8_timer", 32'(rdat8), 5);
        chk("n8_status", 32'(status8), 1);
        addr8 = 8'h80; rden8 = 1; tick(); rden8 = 0;
        chk("n8_unmapped_vld", 32'(rvld8), 0);

        conf8 = 0;
        tick();
        conf8 = 1;
        tick();
        done8 = 1;
        conf8 = 3;
        tick();
        chk("n8_simul_enb", 32'(enb8), 0);
        chk("n8_simul_irq", 32'(irq8), 0);
        conf8 = 0; done8 = 0;
        tick();
        chk("n8_simul_irq2", 32'(irq8), 0);

        tick();
        conf8 = 1;
        repeat (300) tick();
        addr8 = 8'h40; rden8 = 1; tick(); rden8 = 0;
        chk("n8_sat_timer", 32'(rdat8), 32'hFF);
        chk("n8_sat_flag", 32'(dut8.sat_q), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
